// File: rtl/lzrw_pkg.sv
// LZRW stream decompressor shared types, defaults and item field helpers.
// Holds the FSM state enum and offset/length extraction from a copy item.
package lzrw_pkg;

  localparam int OFFSET_BITS_D = 12;
  localparam int LEN_BITS_D    = 4;
  localparam int MIN_MATCH_D   = 3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COPY  = 2'd1,
    S_ERROR = 2'd2
  } state_t;

  function automatic logic [31:0] item_offset(
    input logic [31:0] item,
    input int          lb,
    input int          ob
  );
    return (item >> lb) & ((32'd1 << ob) - 32'd1);
  endfunction

  function automatic logic [31:0] item_len(
    input logic [31:0] item,
    input int          lb,
    input int          mm
  );
    return (item & ((32'd1 << lb) - 32'd1)) + 32'(mm);
  endfunction

endpackage

// File: rtl/lzrw_history_ram.sv
// History buffer: 1 write + 1 synchronous read port, write-first on collision.
// Ports: i_we/i_waddr/i_wdata write, i_re/i_raddr read, o_rdata held between reads.
module lzrw_history_ram #(
  parameter int AW = 12
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [7:0]    i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [7:0]    o_rdata
);

  logic [7:0] r_mem [2**AW];

  always_ff @(posedge i_clk) begin
    if (i_we)
      r_mem[i_waddr] <= i_wdata;
    if (i_re)
      o_rdata <= (i_we && (i_waddr == i_raddr))
               ? i_wdata : r_mem[i_raddr];
  end

endmodule

// File: rtl/lzrw_stream_decompressor.sv
// LZRW1-family decompressor: literal/copy items in, one byte per cycle out.
// Ports: item valid/ready in, byte valid/ready out, flush, busy, error, bytes_out.
module lzrw_stream_decompressor
  import lzrw_pkg::*;
#(
  parameter  int OFFSET_BITS = OFFSET_BITS_D,
  parameter  int LEN_BITS    = LEN_BITS_D,
  parameter  int MIN_MATCH   = MIN_MATCH_D,
  localparam int ITEM_WIDTH  = OFFSET_BITS + LEN_BITS
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_flush,
  input  logic [ITEM_WIDTH-1:0] i_data_in,
  input  logic                  i_control_word_in,
  input  logic                  i_data_in_valid,
  output logic                  o_data_in_ready,
  output logic [7:0]            o_decompressed_byte,
  output logic                  o_out_valid,
  input  logic                  i_out_ready,
  output logic                  o_decompressor_busy,
  output logic                  o_error,
  output logic [31:0]           o_bytes_out
);

  localparam int CW = LEN_BITS + 8;
  localparam logic [OFFSET_BITS:0] FULL =
    (OFFSET_BITS+1)'(2**OFFSET_BITS);

  state_t                 r_state;
  logic [OFFSET_BITS-1:0] r_wr_ptr;
  logic [OFFSET_BITS-1:0] r_wb_addr;
  logic [OFFSET_BITS-1:0] r_off;
  logic [OFFSET_BITS:0]   r_fill;
  logic [CW-1:0]          r_rem;
  logic                   r_wb_valid;
  logic                   r_sel_ram;
  logic                   r_valid;
  logic                   r_error;
  logic [7:0]             r_byte;
  logic [31:0]            r_cnt;

  logic [OFFSET_BITS-1:0] w_offset;
  logic [CW-1:0]          w_len;
  logic [OFFSET_BITS:0]   w_fill_nxt;
  logic [OFFSET_BITS-1:0] w_raddr;
  logic [7:0]             w_rdata;
  logic [7:0]             w_out;
  logic                   w_drain;
  logic                   w_acc;
  logic                   w_bad;
  logic                   w_adv;

  assign w_offset = OFFSET_BITS'(item_offset(
    32'(i_data_in), LEN_BITS, OFFSET_BITS));
  assign w_len = CW'(item_len(
    32'(i_data_in), LEN_BITS, MIN_MATCH));
  assign w_bad = (w_offset == '0) || ({1'b0, w_offset} > r_fill);
  assign w_fill_nxt = (r_fill == FULL) ? r_fill : r_fill + 1'b1;

  assign w_drain = !r_valid || i_out_ready;
  assign o_data_in_ready = i_rst_n && !i_flush && w_drain
                         && (r_state == S_IDLE);
  assign w_acc = i_data_in_valid && o_data_in_ready;
  assign w_adv = (r_state == S_COPY) && w_drain && !i_flush;
  assign w_raddr = r_wr_ptr - r_off;

  // Copy bytes are shown straight from the RAM read register.
  assign w_out = r_sel_ram ? w_rdata : r_byte;

  assign o_decompressed_byte = w_out;
  assign o_out_valid = r_valid;
  assign o_error = r_error;
  assign o_bytes_out = r_cnt;
  assign o_decompressor_busy = (r_state != S_IDLE) || r_valid;

  // The byte now in the output register is written back one cycle
  // after it lands; an offset-1 read then hits the write-first path.
  lzrw_history_ram #(
    .AW (OFFSET_BITS)
  ) u_ram (
    .i_clk   (i_clk),
    .i_we    (r_wb_valid),
    .i_waddr (r_wb_addr),
    .i_wdata (w_out),
    .i_re    (w_adv),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_wr_ptr   <= '0;
      r_wb_addr  <= '0;
      r_off      <= '0;
      r_fill     <= '0;
      r_rem      <= '0;
      r_wb_valid <= 1'b0;
      r_sel_ram  <= 1'b0;
      r_valid    <= 1'b0;
      r_error    <= 1'b0;
      r_byte     <= '0;
      r_cnt      <= '0;
    end else if (i_flush) begin
      r_state    <= S_IDLE;
      r_wr_ptr   <= '0;
      r_fill     <= '0;
      r_rem      <= '0;
      r_wb_valid <= 1'b0;
      r_sel_ram  <= 1'b0;
      r_valid    <= 1'b0;
      r_error    <= 1'b0;
      r_byte     <= '0;
      r_cnt      <= '0;
    end else begin
      r_wb_valid <= 1'b0;
      if (r_valid && i_out_ready)
        r_cnt <= r_cnt + 32'd1;
      if (w_drain)
        r_valid <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_acc && !i_control_word_in) begin
            r_byte     <= i_data_in[7:0];
            r_sel_ram  <= 1'b0;
            r_valid    <= 1'b1;
            r_wb_valid <= 1'b1;
            r_wb_addr  <= r_wr_ptr;
            r_wr_ptr   <= r_wr_ptr + 1'b1;
            r_fill     <= w_fill_nxt;
          end else if (w_acc && w_bad) begin
            r_state <= S_ERROR;
            r_error <= 1'b1;
          end else if (w_acc && (w_len != '0)) begin
            r_off   <= w_offset;
            r_rem   <= w_len;
            r_state <= S_COPY;
          end
        end
        S_COPY: begin
          if (w_adv) begin
            r_sel_ram  <= 1'b1;
            r_valid    <= 1'b1;
            r_wb_valid <= 1'b1;
            r_wb_addr  <= r_wr_ptr;
            r_wr_ptr   <= r_wr_ptr + 1'b1;
            r_fill     <= w_fill_nxt;
            r_rem      <= r_rem - 1'b1;
            if (r_rem == CW'(1))
              r_state <= S_IDLE;
          end
        end
        S_ERROR: begin
          r_valid <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lzrw_stream_decompressor.sv
// Self-checking bench: directed scenarios plus random items vs a byte-stream model.
// Model tracks produced history as a plain queue and expected output bytes.
module tb_lzrw_stream_decompressor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic [15:0] data_in = '0;
  logic        ctl = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  dbyte;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        busy;
  logic        err;
  logic [31:0] bytes_out;

  lzrw_stream_decompressor dut (
    .i_clk               (clk),
    .i_rst_n             (rst_n),
    .i_flush             (flush),
    .i_data_in           (data_in),
    .i_control_word_in   (ctl),
    .i_data_in_valid     (in_valid),
    .o_data_in_ready     (in_ready),
    .o_decompressed_byte (dbyte),
    .o_out_valid         (out_valid),
    .i_out_ready         (out_ready),
    .o_decompressor_busy (busy),
    .o_error             (err),
    .o_bytes_out         (bytes_out)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err = 0;

  logic [7:0]  m_q[$];
  logic [7:0]  m_hist[$];
  logic [7:0]  got[$];
  int unsigned m_cnt = 0;
  bit          m_err = 1'b0;
  int          mode = 0;

  task automatic chk(input string nm, input logic [31:0] a,
                     input logic [31:0] e);
    n_checks++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, a, e, $time);
    end
  endtask

  function automatic void model_clear();
    m_q.delete();
    m_hist.delete();
    m_cnt = 0;
    m_err = 1'b0;
  endfunction

  function automatic int fill_now();
    return (m_hist.size() > 4096) ? 4096 : m_hist.size();
  endfunction

  function automatic void model_accept(input bit c, input logic [15:0] d);
    int off;
    int len;
    logic [7:0] b;
    if (!c) begin
      m_q.push_back(d[7:0]);
      m_hist.push_back(d[7:0]);
    end else begin
      off = int'(d[15:4]);
      len = int'(d[3:0]) + 3;
      if (off == 0 || off > fill_now()) begin
        m_err = 1'b1;
      end else begin
        for (int i = 0; i < len; i++) begin
          b = m_hist[m_hist.size() - off];
          m_hist.push_back(b);
          m_q.push_back(b);
        end
      end
    end
  endfunction

  // out_ready pattern: 0 always high, 1 toggling, 2 random
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (mode == 0) out_ready = 1'b1;
      else if (mode == 1) out_ready = ~out_ready;
      else out_ready = 1'($urandom_range(0, 1));
    end
  end

  // Compare process: every cycle, away from the active edge.
  bit         prev_stall = 1'b0;
  logic [7:0] prev_byte = '0;
  initial begin
    int pend;
    bit exp_rdy;
    bit exp_busy;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_byte", 32'(dbyte), 0);
        chk("rst_error", 32'(err), 0);
        chk("rst_bytes_out", bytes_out, 0);
        chk("rst_ready", 32'(in_ready), 0);
        model_clear();
        prev_stall = 1'b0;
      end else begin
        pend = m_q.size() - (out_valid ? 1 : 0);
        exp_rdy = !m_err && pend <= 0 && (!out_valid || out_ready) && !flush;
        exp_busy = out_valid || pend > 0 || m_err;
        chk("ready", 32'(in_ready), 32'(exp_rdy));
        chk("busy", 32'(busy), 32'(exp_busy));
        chk("error", 32'(err), 32'(m_err));
        chk("bytes_out", bytes_out, m_cnt);
        if (prev_stall) begin
          chk("stall_valid", 32'(out_valid), 1);
          chk("stall_byte", 32'(dbyte), 32'(prev_byte));
        end
        if (out_valid) begin
          if (m_q.size() == 0) begin
            chk("spurious_valid", 32'(out_valid), 0);
          end else begin
            chk("byte", 32'(dbyte), 32'(m_q[0]));
            if (out_ready) begin
              void'(m_q.pop_front());
              m_cnt++;
              got.push_back(dbyte);
            end
          end
        end
        prev_stall = out_valid && !out_ready && !flush;
        prev_byte = dbyte;
        if (flush) begin
          model_clear();
          prev_stall = 1'b0;
        end
      end
    end
  end

  task automatic send(input bit c, input logic [15:0] d);
    bit ok;
    ok = 1'b0;
    ctl = c;
    data_in = d;
    in_valid = 1'b1;
    for (int k = 0; k < 400 && !ok; k++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      @(posedge clk);
      if (ok) model_accept(c, d);
    end
    #1;
    in_valid = 1'b0;
    if (!ok) chk("send_timeout", 0, 1);
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int k = 0; k < 4000 && !done; k++) begin
      @(negedge clk);
      if (m_q.size() == 0) done = 1'b1;
    end
    @(posedge clk);
    #1;
    if (!done) chk("drain_timeout", 32'(m_q.size()), 0);
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
  endtask

  task automatic chk_got(input string nm, input string s);
    chk({nm, "_len"}, 32'(got.size()), 32'(s.len()));
    for (int i = 0; i < s.len() && i < got.size(); i++)
      chk(nm, 32'(got[i]), 32'(s[i]));
  endtask

  initial begin
    string s;
    int    fl;
    int    off;
    int    r;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // abc then copy offset 3 len 6
    got.delete();
    send(1'b0, 16'h0061);
    chk("lit_lat_valid", 32'(out_valid), 1);
    chk("lit_lat_byte", 32'(dbyte), 32'h61);
    send(1'b0, 16'h0062);
    send(1'b0, 16'h0063);
    drain();
    chk("abc_bytes_out", bytes_out, 3);
    send(1'b1, 16'h0033);
    chk("copy_lat_n1", 32'(out_valid), 0);
    @(posedge clk);
    #1;
    chk("copy_lat_n2", 32'(out_valid), 1);
    chk("copy_first", 32'(dbyte), 32'h61);
    drain();
    chk_got("abcabc", "abcabcabc");
    chk("abcabc_bytes_out", bytes_out, 9);

    // overlap: offset 1
    got.delete();
    send(1'b0, 16'h0078);
    send(1'b1, 16'h0011);
    drain();
    chk_got("overlap", "xxxxx");

    // first item invalid copy -> error, then flush
    do_flush();
    send(1'b1, 16'h0010);
    for (int i = 0; i < 3; i++) begin
      chk("err_flag", 32'(err), 1);
      chk("err_valid", 32'(out_valid), 0);
      chk("err_ready", 32'(in_ready), 0);
      @(posedge clk);
      #1;
    end
    do_flush();
    chk("flush_err", 32'(err), 0);
    got.delete();
    send(1'b0, 16'h0041);
    drain();
    chk_got("after_flush", "A");
    chk("after_flush_cnt", bytes_out, 1);

    // 18-byte copy with out_ready toggling
    do_flush();
    got.delete();
    send(1'b0, 16'h0030);
    send(1'b0, 16'h0031);
    send(1'b0, 16'h0032);
    send(1'b0, 16'h0033);
    mode = 1;
    send(1'b1, 16'h004F);
    drain();
    mode = 0;
    @(posedge clk);
    #1;
    chk_got("stall_copy", "0123012301230123012301");

    // reset mid-copy
    send(1'b1, 16'h004F);
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 0);
    chk("arst_byte", 32'(dbyte), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_bytes_out", bytes_out, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    got.delete();
    send(1'b0, 16'h0055);
    drain();
    chk_got("post_reset", "U");
    chk("post_reset_cnt", bytes_out, 1);

    // random items, random backpressure
    do_flush();
    mode = 2;
    for (int n = 0; n < 1500; n++) begin
      fl = fill_now();
      r = int'($urandom_range(0, 199));
      if (fl == 0 || r < 120) begin
        send(1'b0, 16'($urandom_range(0, 255)));
      end else if (r < 199) begin
        off = int'($urandom_range(1, fl));
        send(1'b1, {12'(off), 4'($urandom_range(0, 15))});
      end else begin
        off = (fl < 4095) ? fl + 1 : 0;
        send(1'b1, {12'(off), 4'($urandom_range(0, 15))});
        @(posedge clk);
        #1;
        chk("rand_err", 32'(err), 1);
        do_flush();
      end
    end
    drain();
    mode = 0;
    repeat (2) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/lzrw_stream_decompressor.md
# lzrw_stream_decompressor

Parametrised LZRW1-family decompressor: accepts one compressed item per handshake (16-bit-class item plus its control bit) and emits the reconstructed byte stream one byte per cycle with valid/ready backpressure on both sides. It is the next generation of decompressor_top, adding generic offset/length field widths, output backpressure, overlapped-copy support, history-validity error detection and a synchronous stream flush. It sits between the compressed-item source (file reader / DMA) and the byte sink.

## Interface
- OFFSET_BITS, 12, copy-offset field width; history depth = 2**OFFSET_BITS bytes
- LEN_BITS, 4, copy-length field width
- MIN_MATCH, 3, length encoded as field value + MIN_MATCH
- ITEM_WIDTH (localparam) = OFFSET_BITS+LEN_BITS; must be ≥ 8
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- flush  in  1  synchronous stream restart; highest priority after reset
- data_in  in  ITEM_WIDTH  item: literal in [7:0], or copy {offset[ITEM_WIDTH-1:LEN_BITS], len_field[LEN_BITS-1:0]}
- control_word_in  in  1  0 = literal, 1 = copy
- data_in_valid  in  1  item offered
- data_in_ready  out  1  item accepted on valid && ready
- decompressed_byte  out  8  output byte
- out_valid  out  1  output byte present
- out_ready  in  1  sink accepts byte on out_valid && out_ready
- decompressor_busy  out  1  state != IDLE or out_valid
- error  out  1  sticky malformed-stream flag
- bytes_out  out  32  count of output handshakes since reset/flush, wraps

## Operation
- States: IDLE, COPY, ERROR.
- Reset/flush: state IDLE, out_valid 0, decompressed_byte 0, error 0, bytes_out 0, write pointer 0, history-fill count 0, data_in_ready 0 while reset low. History RAM contents are not cleared.
- data_in_ready = (state == IDLE) && (!out_valid || out_ready).
- Literal accepted: data_in[7:0] loaded into output register and written to history at wr_ptr; wr_ptr++, fill count++ (saturates at 2**OFFSET_BITS). Remains IDLE.
- Copy accepted: offset = data_in[ITEM_WIDTH-1:LEN_BITS], length = len_field + MIN_MATCH. If offset == 0 or offset > fill count -> ERROR, no bytes emitted. Otherwise -> COPY with remaining = length.
- COPY: each advancing cycle issues history read at wr_ptr − offset (mod depth). Returned byte is loaded to the output register and written back at wr_ptr. Advance only when output register is empty or drained this cycle. Last read issued -> IDLE.
- Overlap (offset < length, incl. offset 1) is legal. The history RAM is write-first, so a same-cycle read returns the byte being written.
- ERROR: data_in_ready 0, out_valid 0, error 1; exit only by reset or flush.
- Pointer arithmetic modulo 2**OFFSET_BITS; bytes_out wraps at 2**32.

## Timing
- Literal accepted at edge N -> out_valid from N+1. With out_ready=1, literals sustain 1 item/cycle.
- Copy accepted at N -> first byte valid N+2, one byte/cycle thereafter, last byte valid N+1+length. data_in_ready is high again from N+1+length if out_ready=1.
- out_ready low: decompressed_byte and out_valid hold stable, no RAM read or pointer advance.
- flush in any state takes effect the next edge and drops an in-flight copy and any pending output byte. flush concurrent with data_in_valid drops the item (ready forced 0 that cycle).
- Reset asserted mid-copy: all outputs return to reset values asynchronously.

## Structure
- lzrw_pkg: state enum, default OFFSET_BITS/LEN_BITS/MIN_MATCH, functions extracting offset/length from an item.
- Sub-module lzrw_history_ram: single-clock, 1 write + 1 read port, synchronous read, write-first on address collision, depth 2**OFFSET_BITS × 8.

## Test plan
- Literals 0x61,0x62,0x63 back-to-back, out_ready=1 -> "abc" on N+1..N+3, bytes_out=3.
- After "abc", copy 16'h0033 (offset 3, len 6) -> "abcabc", first byte 2 cycles after acceptance, 9 total bytes.
- Literal 'x' then copy 16'h0011 (offset 1, len 4) -> "xxxxx", which checks the write-first overlap path.
- First item copy 16'h0010 -> error=1, no out_valid, data_in_ready stays 0. Pulse flush -> error=0 and literal 0x41 emits 'A'.
- Copy len field 0xF (18 bytes) with out_ready toggled 1/0 every cycle -> byte held stable while stalled, correct 18-byte sequence, data_in_ready low throughout.
- Reset asserted mid-copy, then released -> all outputs at reset values, next literal emits correctly with bytes_out=1.
